mem_stage: RTL and testbench

- The MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register fields and holds a byte-addressed, big-endian data memory.
- It performs word stores and word/half/byte loads.
- It resolves the branch decision for IF.
- It drives the MEM/WB pipeline register that the writeback stage and the pipeline monitor observe.
- It supports an optional multi-cycle memory with a stall output.

---
 rtl/mips_defs.sv | 18 +
 rtl/data_memory.sv | 56 +++++
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: load-mode encodings, MEM-stage FSM states
// and default datapath widths.
package mips_defs;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    localparam logic [1:0] LOAD_WORD   = 2'b00;
    localparam logic [1:0] LOAD_HALF   = 2'b01;
    localparam logic [1:0] LOAD_BYTE   = 2'b10;
    localparam logic [1:0] LOAD_BYTE_U = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Big-endian byte-addressed data memory: aligned word writes and combinational
// word/half/byte loads with sign or zero extension.
module data_memory
    import mips_defs::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_BYTES  = 1024,
    parameter int ADDR_BITS  = $clog2(MEM_BYTES)
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_BITS-1:0]  byte_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [1:0]            load_mode,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [7:0]           mem [MEM_BYTES];
    logic [ADDR_BITS-3:0] word_idx;
    logic [31:0]          word;
    logic [15:0]          half;
    logic [7:0]           byte_val;

    assign word_idx = byte_addr[ADDR_BITS-1:2];

    // Byte 0 of a word sits in the most significant lane.
    always_comb begin
        word = '0;
        for (int i = 0; i < 4; i++) begin
            word[8*(3-i) +: 8] = mem[{word_idx, 2'(i)}];
        end
    end

    assign half     = byte_addr[1] ? word[15:0] : word[31:16];
    assign byte_val = word[8*(3-int'(byte_addr[1:0])) +: 8];

    always_comb begin
        read_data = '0;
        case (load_mode)
            LOAD_WORD:   read_data = DATA_WIDTH'(word);
            LOAD_HALF:   read_data = {{(DATA_WIDTH-16){half[15]}}, half};
            LOAD_BYTE:   read_data = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
            LOAD_BYTE_U: read_data = {{(DATA_WIDTH-8){1'b0}}, byte_val};
            default:     read_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                mem[{word_idx, 2'(i)}] <= write_data[8*(3-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, optional multi-cycle memory access FSM
// with stall, and the MEM/WB pipeline register.
module mem_stage
    import mips_defs::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int MEM_BYTES      = 1024,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MEM_reg_write,
    input  logic                      MEM_mem_write,
    input  logic                      MEM_mem_read,
    input  logic                      MEM_mem_to_reg,
    input  logic                      MEM_branch,
    input  logic                      MEM_zero,
    input  logic [DATA_WIDTH-1:0]     MEM_address,
    input  logic [DATA_WIDTH-1:0]     MEM_write_data,
    input  logic [REG_ADDR_WIDTH-1:0] MEM_write_back_destination,
    input  logic [1:0]                MEM_load_mode,
    output logic                      PCSrc,
    output logic                      stall,
    output logic [REG_ADDR_WIDTH-1:0] WB_write_back_destination,
    output logic                      WB_reg_write,
    output logic [DATA_WIDTH-1:0]     WB_read_data,
    output logic [DATA_WIDTH-1:0]     WB_address,
    output logic                      WB_mem_to_reg
);

    localparam int ADDR_BITS = $clog2(MEM_BYTES);
    localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_t             state, next_state;
    logic [CNT_W-1:0]       count, next_count;
    logic                   access;
    logic                   complete;
    logic [DATA_WIDTH-1:0]  load_data;

    assign PCSrc  = MEM_branch & MEM_zero;
    assign access = MEM_mem_read | MEM_mem_write;

    // An access completes only in its final cycle; earlier cycles stall and emit bubbles.
    always_comb begin
        next_state = state;
        next_count = count;
        stall      = 1'b0;
        complete   = 1'b1;
        if (WAIT_CYCLES != 0) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        stall      = 1'b1;
                        complete   = 1'b0;
                        next_count = CNT_W'(WAIT_CYCLES - 1);
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        stall      = 1'b1;
                        complete   = 1'b0;
                        next_count = count - 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    data_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_BYTES  (MEM_BYTES),
        .ADDR_BITS  (ADDR_BITS)
    ) u_mem (
        .clk        (clk),
        .write_en   (MEM_mem_write & complete & ~rst),
        .byte_addr  (MEM_address[ADDR_BITS-1:0]),
        .write_data (MEM_write_data),
        .load_mode  (MEM_load_mode),
        .read_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            count                     <= '0;
            WB_write_back_destination <= '0;
            WB_reg_write              <= 1'b0;
            WB_read_data              <= '0;
            WB_address                <= '0;
            WB_mem_to_reg             <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (complete) begin
                WB_write_back_destination <= MEM_write_back_destination;
                WB_reg_write              <= MEM_reg_write;
                WB_read_data              <= load_data;
                WB_address                <= MEM_address;
                WB_mem_to_reg             <= MEM_mem_to_reg;
            end else begin
                WB_write_back_destination <= '0;
                WB_reg_write              <= 1'b0;
                WB_read_data              <= '0;
                WB_address                <= '0;
                WB_mem_to_reg             <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: three instances with WAIT_CYCLES
// 0, 2 and 3 share stimulus; the idle ones are held in reset.
module tb_mem_stage;
    import mips_defs::*;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst0, rst2, rst3;
    logic        reg_write, mem_write, mem_read, mem_to_reg, branch, zero;
    logic [31:0] address, write_data;
    logic [4:0]  dest;
    logic [1:0]  load_mode;

    logic        pc_src  [3];
    logic        stall   [3];
    logic [4:0]  wb_dest [3];
    logic        wb_rw   [3];
    logic [31:0] wb_rd   [3];
    logic [31:0] wb_addr [3];
    logic        wb_m2r  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.MEM_BYTES(MB), .WAIT_CYCLES(0)) d0 (
        .clk(clk), .rst(rst0),
        .MEM_reg_write(reg_write), .MEM_mem_write(mem_write), .MEM_mem_read(mem_read),
        .MEM_mem_to_reg(mem_to_reg), .MEM_branch(branch), .MEM_zero(zero),
        .MEM_address(address), .MEM_write_data(write_data),
        .MEM_write_back_destination(dest), .MEM_load_mode(load_mode),
        .PCSrc(pc_src[0]), .stall(stall[0]), .WB_write_back_destination(wb_dest[0]),
        .WB_reg_write(wb_rw[0]), .WB_read_data(wb_rd[0]), .WB_address(wb_addr[0]),
        .WB_mem_to_reg(wb_m2r[0])
    );

    mem_stage #(.MEM_BYTES(MB), .WAIT_CYCLES(2)) d2 (
        .clk(clk), .rst(rst2),
        .MEM_reg_write(reg_write), .MEM_mem_write(mem_write), .MEM_mem_read(mem_read),
        .MEM_mem_to_reg(mem_to_reg), .MEM_branch(branch), .MEM_zero(zero),
        .MEM_address(address), .MEM_write_data(write_data),
        .MEM_write_back_destination(dest), .MEM_load_mode(load_mode),
        .PCSrc(pc_src[1]), .stall(stall[1]), .WB_write_back_destination(wb_dest[1]),
        .WB_reg_write(wb_rw[1]), .WB_read_data(wb_rd[1]), .WB_address(wb_addr[1]),
        .WB_mem_to_reg(wb_m2r[1])
    );

    mem_stage #(.MEM_BYTES(MB), .WAIT_CYCLES(3)) d3 (
        .clk(clk), .rst(rst3),
        .MEM_reg_write(reg_write), .MEM_mem_write(mem_write), .MEM_mem_read(mem_read),
        .MEM_mem_to_reg(mem_to_reg), .MEM_branch(branch), .MEM_zero(zero),
        .MEM_address(address), .MEM_write_data(write_data),
        .MEM_write_back_destination(dest), .MEM_load_mode(load_mode),
        .PCSrc(pc_src[2]), .stall(stall[2]), .WB_write_back_destination(wb_dest[2]),
        .WB_reg_write(wb_rw[2]), .WB_read_data(wb_rd[2]), .WB_address(wb_addr[2]),
        .WB_mem_to_reg(wb_m2r[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic wr, input logic rd,
                                 input logic m2r, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] d,
                                 input logic [1:0] mode);
        reg_write  = rw;
        mem_write  = wr;
        mem_read   = rd;
        mem_to_reg = m2r;
        address    = addr;
        write_data = wdata;
        dest       = d;
        load_mode  = mode;
        branch     = 1'b0;
        zero       = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkWbZero(input string tag, input int k);
        checkOutput({tag, " rd"},   wb_rd[k],   32'h0);
        checkOutput({tag, " rw"},   32'(wb_rw[k]),   32'h0);
        checkOutput({tag, " addr"}, wb_addr[k], 32'h0);
        checkOutput({tag, " dest"}, 32'(wb_dest[k]), 32'h0);
        checkOutput({tag, " m2r"},  32'(wb_m2r[k]),  32'h0);
    endtask

    initial begin
        logic [31:0] word4;

        rst0 = 1'b1;
        rst2 = 1'b1;
        rst3 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, LOAD_WORD);

        d0.u_mem.mem[0] = 8'h11; d0.u_mem.mem[1] = 8'h22; d0.u_mem.mem[2] = 8'h33; d0.u_mem.mem[3] = 8'h44;
        d2.u_mem.mem[0] = 8'h11; d2.u_mem.mem[1] = 8'h22; d2.u_mem.mem[2] = 8'h33; d2.u_mem.mem[3] = 8'h44;
        d3.u_mem.mem[4] = 8'hCA; d3.u_mem.mem[5] = 8'hFE; d3.u_mem.mem[6] = 8'hBA; d3.u_mem.mem[7] = 8'hBE;
        d0.u_mem.mem[8] = 8'h80; d0.u_mem.mem[9] = 8'h01; d0.u_mem.mem[10] = 8'hFE; d0.u_mem.mem[11] = 8'h7F;

        tick();
        tick();
        $display("[TB] reset state");
        checkWbZero("reset d0", 0);
        checkOutput("reset stall d0", 32'(stall[0]), 32'h0);
        checkOutput("reset stall d2", 32'(stall[1]), 32'h0);

        // Single-cycle memory: loads land in MEM/WB one cycle after issue.
        rst0 = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd8, 32'h0, 5'd5, LOAD_WORD);
        tick();
        checkOutput("lw@8 data", wb_rd[0], 32'h8001FE7F);
        checkOutput("lw@8 rw",   32'(wb_rw[0]), 32'h1);
        checkOutput("lw@8 addr", wb_addr[0], 32'd8);
        checkOutput("lw@8 dest", 32'(wb_dest[0]), 32'd5);
        checkOutput("lw@8 m2r",  32'(wb_m2r[0]), 32'h1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd10, 32'h0, 5'd6, LOAD_HALF);
        tick();
        checkOutput("lh@10", wb_rd[0], 32'hFFFFFE7F);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd9, 32'h0, 5'd6, LOAD_BYTE);
        tick();
        checkOutput("lb@9", wb_rd[0], 32'h00000001);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd10, 32'h0, 5'd6, LOAD_BYTE_U);
        tick();
        checkOutput("lbu@10", wb_rd[0], 32'h000000FE);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd13, 32'hDEADBEEF, 5'd0, LOAD_WORD);
        tick();
        checkOutput("sw rw", 32'(wb_rw[0]), 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd12, 32'h0, 5'd7, LOAD_WORD);
        tick();
        checkOutput("lw@12", wb_rd[0], 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd13, 32'h0, 5'd7, LOAD_BYTE);
        tick();
        checkOutput("lb@13", wb_rd[0], 32'hFFFFFFAD);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'(MB + 8), 32'h0, 5'd8, LOAD_WORD);
        tick();
        checkOutput("lw wrap", wb_rd[0], 32'h8001FE7F);

        // Simultaneous read and write returns the old word, then the new one is visible.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 32'h12345678, 5'd9, LOAD_WORD);
        tick();
        checkOutput("rbw old", wb_rd[0], 32'h8001FE7F);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd8, 32'h0, 5'd9, LOAD_WORD);
        tick();
        checkOutput("rbw new", wb_rd[0], 32'h12345678);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, LOAD_WORD);
        branch = 1'b1;
        zero   = 1'b1;
        #1;
        checkOutput("pcsrc taken", 32'(pc_src[0]), 32'h1);
        zero = 1'b0;
        #1;
        checkOutput("pcsrc not taken", 32'(pc_src[0]), 32'h0);
        tick();

        $display("[TB] WAIT_CYCLES=2 load");
        rst0 = 1'b1;
        rst2 = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'h0, 5'd3, LOAD_WORD);
        #1;
        checkOutput("w2 stall c1", 32'(stall[1]), 32'h1);
        tick();
        checkOutput("w2 stall c2", 32'(stall[1]), 32'h1);
        checkOutput("w2 bubble c1", 32'(wb_rw[1]), 32'h0);
        tick();
        checkOutput("w2 stall c3", 32'(stall[1]), 32'h0);
        checkOutput("w2 bubble c2", 32'(wb_rw[1]), 32'h0);
        tick();
        checkOutput("w2 lw data", wb_rd[1], 32'h11223344);
        checkOutput("w2 lw rw",   32'(wb_rw[1]), 32'h1);
        checkOutput("w2 lw dest", 32'(wb_dest[1]), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd7, LOAD_WORD);
        #1;
        checkOutput("w2 alu stall", 32'(stall[1]), 32'h0);
        tick();
        checkOutput("w2 alu addr", wb_addr[1], 32'h55);
        checkOutput("w2 alu dest", 32'(wb_dest[1]), 32'd7);
        checkOutput("w2 alu m2r",  32'(wb_m2r[1]), 32'h0);
        checkOutput("w2 alu rw",   32'(wb_rw[1]), 32'h1);

        $display("[TB] WAIT_CYCLES=3 store aborted by reset");
        rst2 = 1'b1;
        rst3 = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 32'h01020304, 5'd0, LOAD_WORD);
        #1;
        checkOutput("w3 stall c1", 32'(stall[2]), 32'h1);
        tick();
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, LOAD_WORD);
        #1;
        checkOutput("w3 stall after rst", 32'(stall[2]), 32'h0);
        checkWbZero("w3 after rst", 2);
        word4 = {d3.u_mem.mem[4], d3.u_mem.mem[5], d3.u_mem.mem[6], d3.u_mem.mem[7]};
        checkOutput("w3 word@4", word4, 32'hCAFEBABE);
        tick();
        tick();
        tick();
        word4 = {d3.u_mem.mem[4], d3.u_mem.mem[5], d3.u_mem.mem[6], d3.u_mem.mem[7]};
        checkOutput("w3 word@4 later", word4, 32'hCAFEBABE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
